// File: rtl/riscv_muldiv_iter.sv
// Iterative RV32M multiply/divide unit.
// Radix-2 shift-add multiply and restoring shift-subtract divide. The latency
// is fixed: the response appears 34 cycles after the request is accepted.
// The result is held on the response port until the consumer takes it.
module riscv_muldiv_iter #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_req_valid,
    output logic             io_req_ready,
    input  logic [2:0]       io_req_fn,
    input  logic [XLEN-1:0]  io_req_in1,
    input  logic [XLEN-1:0]  io_req_in2,
    input  logic [TAG_W-1:0] io_req_tag,
    input  logic             io_kill,
    output logic             io_resp_valid,
    input  logic             io_resp_ready,
    output logic [XLEN-1:0]  io_resp_data,
    output logic [TAG_W-1:0] io_resp_tag
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    localparam logic [2:0] FN_MUL    = 3'd0;
    localparam logic [2:0] FN_MULH   = 3'd1;
    localparam logic [2:0] FN_MULHSU = 3'd2;
    localparam logic [2:0] FN_MULHU  = 3'd3;
    localparam logic [2:0] FN_DIV    = 3'd4;
    localparam logic [2:0] FN_DIVU   = 3'd5;
    localparam logic [2:0] FN_REM    = 3'd6;
    localparam logic [2:0] FN_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FIX,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]  count;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   divisor;
    logic [XLEN-1:0]   in1_raw;
    logic [2:0]        fn;
    logic [TAG_W-1:0]  tag;
    logic              neg_out;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   resp_data;
    logic [TAG_W-1:0]  resp_tag;

    logic              req_fire;
    logic              in1_signed;
    logic              in2_signed;
    logic              sign1;
    logic              sign2;
    logic [XLEN-1:0]   abs1;
    logic [XLEN-1:0]   abs2;
    logic              neg_req;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   result;

    assign io_req_ready  = (state == IDLE);
    assign io_resp_valid = (state == DONE);
    assign io_resp_data  = resp_data;
    assign io_resp_tag   = resp_tag;

    // A kill in the same cycle as a request drops the request.
    assign req_fire = io_req_valid & io_req_ready & ~io_kill;

    // Operand conditioning: signed operands become magnitudes, the sign of the
    // final result is remembered in neg_out.
    always_comb begin
        sign1      = io_req_in1[XLEN-1];
        sign2      = io_req_in2[XLEN-1];
        in1_signed = (io_req_fn == FN_MULH) || (io_req_fn == FN_MULHSU) ||
                     (io_req_fn == FN_DIV)  || (io_req_fn == FN_REM);
        in2_signed = (io_req_fn == FN_MULH) || (io_req_fn == FN_DIV) ||
                     (io_req_fn == FN_REM);
        abs1       = (in1_signed && sign1) ? ({XLEN{1'b0}} - io_req_in1) : io_req_in1;
        abs2       = (in2_signed && sign2) ? ({XLEN{1'b0}} - io_req_in2) : io_req_in2;
        if (io_req_fn == FN_REM) begin
            neg_req = sign1;
        end else begin
            neg_req = (in1_signed & sign1) ^ (in2_signed & sign2);
        end
    end

    // One datapath step: shift-add for multiply, trial subtract for divide.
    // The multiplier/dividend lives in the low half of acc and is consumed
    // one bit per cycle while the product/remainder grows in the high half.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, divisor} : {(XLEN+1){1'b0}});
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        rem_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = rem_shift - {1'b0, divisor};
        if (div_diff[XLEN]) begin
            div_next = {rem_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end
    end

    // Sign fix-up and result selection, with the divide special cases
    // overriding whatever the datapath produced.
    always_comb begin
        prod_fix = neg_out ? ({(2*XLEN){1'b0}} - acc) : acc;
        quot_fix = neg_out ? ({XLEN{1'b0}} - acc[XLEN-1:0]) : acc[XLEN-1:0];
        rem_fix  = neg_out ? ({XLEN{1'b0}} - acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
        result   = {XLEN{1'b0}};
        case (fn)
            FN_MUL:    result = prod_fix[XLEN-1:0];
            FN_MULH,
            FN_MULHSU,
            FN_MULHU:  result = prod_fix[2*XLEN-1:XLEN];
            FN_DIV: begin
                if (div_zero) begin
                    result = {XLEN{1'b1}};
                end else if (div_ovf) begin
                    result = {1'b1, {(XLEN-1){1'b0}}};
                end else begin
                    result = quot_fix;
                end
            end
            FN_DIVU:   result = div_zero ? {XLEN{1'b1}} : quot_fix;
            FN_REM: begin
                if (div_zero) begin
                    result = in1_raw;
                end else if (div_ovf) begin
                    result = {XLEN{1'b0}};
                end else begin
                    result = rem_fix;
                end
            end
            FN_REMU:   result = div_zero ? in1_raw : rem_fix;
            default:   result = {XLEN{1'b0}};
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. BUSY holds for XLEN+1 cycles: XLEN iterations plus
    // the cycle that sees the terminal count, which gives the fixed latency.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req_fire) state_next = BUSY;
            BUSY: begin
                if (io_kill) begin
                    state_next = IDLE;
                end else if (count == CNT_W'(XLEN)) begin
                    state_next = FIX;
                end
            end
            FIX:  state_next = io_kill ? IDLE : DONE;
            DONE: if (io_resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers: capture on accept, iterate in BUSY, latch the
    // response in FIX and leave it untouched until the next FIX.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            acc       <= '0;
            divisor   <= '0;
            in1_raw   <= '0;
            fn        <= '0;
            tag       <= '0;
            neg_out   <= 1'b0;
            div_zero  <= 1'b0;
            div_ovf   <= 1'b0;
            resp_data <= '0;
            resp_tag  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        fn       <= io_req_fn;
                        tag      <= io_req_tag;
                        acc      <= {{XLEN{1'b0}}, abs1};
                        divisor  <= abs2;
                        in1_raw  <= io_req_in1;
                        neg_out  <= neg_req;
                        div_zero <= (io_req_in2 == {XLEN{1'b0}});
                        div_ovf  <= (io_req_in1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                                    (io_req_in2 == {XLEN{1'b1}});
                        count    <= '0;
                    end
                end
                BUSY: begin
                    if (!io_kill && (count != CNT_W'(XLEN))) begin
                        acc   <= fn[2] ? div_next : mul_next;
                        count <= count + 1'b1;
                    end
                end
                FIX: begin
                    if (!io_kill) begin
                        resp_data <= result;
                        resp_tag  <= tag;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
